// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, glitch filter, frame checker, E0/F0
// prefix folding and a show-ahead FIFO of decoded scan codes.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     rd_en,
    output logic [7:0]               code_out,
    output logic                     code_break,
    output logic                     code_ext,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frame_err,
    output logic                     parity_err,
    input  logic                     err_clr,
    output logic [1:0]               fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_s, data_s;
    logic                   filt_q, filt_d, fall;
    logic [FW-1:0]          fcnt_q, fcnt_d;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          wd_q, wd_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   push_en, set_frame, set_parity;
    logic [9:0]             push_data;

    logic [9:0]             mem_q [0:DEPTH-1];
    logic [AW:0]            wr_q, rd_q, count_w;
    logic [9:0]             last_q, head;
    logic                   full, do_pop, do_push, ovf_set;
    logic                   overflow_q, frame_err_q, parity_err_q;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // The filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
            else                               fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        wd_d       = '0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        push_en    = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        push_data  = {ext_q, brk_q, shift_q};
        // Watchdog: a stalled frame is dropped but pending prefixes survive.
        if (state_q != S_IDLE && !fall) begin
            if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                set_frame = 1'b1;
                state_d   = S_IDLE;
            end else begin
                wd_d = wd_q + TW'(1);
            end
        end
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        set_frame = 1'b1;
                        ext_d     = 1'b0;
                        brk_d     = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_s;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (data_s && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0)      ext_d = 1'b1;
                        else if (shift_q == 8'hF0) brk_d = 1'b1;
                        else begin
                            push_en = 1'b1;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    end else begin
                        set_frame  = ~data_s;
                        set_parity = ~(^{shift_q, par_q});
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign count_w = wr_q - rd_q;
    assign valid   = (count_w != '0);
    assign full    = (count_w == (AW+1)'(DEPTH));
    assign do_pop  = rd_en & valid;
    assign do_push = push_en & (~full | do_pop);
    assign ovf_set = push_en & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    // last_q keeps the most recently popped entry visible while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            last_q       <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop) begin
                rd_q   <= rd_q + (AW+1)'(1);
                last_q <= mem_q[rd_q[AW-1:0]];
            end
            overflow_q   <= ovf_set    | (overflow_q   & ~err_clr);
            frame_err_q  <= set_frame  | (frame_err_q  & ~err_clr);
            parity_err_q <= set_parity | (parity_err_q & ~err_clr);
        end
    end

    assign head       = valid ? mem_q[rd_q[AW-1:0]] : last_q;
    assign code_out   = head[7:0];
    assign code_break = head[8];
    assign code_ext   = head[9];
    assign count      = count_w;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign fsm_state  = state_q;
endmodule
